// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX-stage operand forwarding and load-use stall detection
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             hold,
    input  logic             flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    // Producer-side view of an in-flight instruction.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stage_t           ex_q,  ex_d;
    stage_t           mem_q, mem_d;
    stage_t           wb_q,  wb_d;
    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_can_fwd;
    logic wb_can_fwd;
    logic ex_is_load;
    logic ex_bubble;

    // A stage can forward only if it really writes a register other than x0.
    always_comb begin
        mem_can_fwd = mem_q.valid & mem_q.regwrite & (mem_q.rd != 5'd0);
        wb_can_fwd  = wb_q.valid  & wb_q.regwrite  & (wb_q.rd  != 5'd0);
        ex_is_load  = ex_q.valid  & ex_q.memread   & (ex_q.rd  != 5'd0);
    end

    // Operand mux selects; MEM is checked first so the youngest producer wins.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (mem_can_fwd && (mem_q.rd == ex_rs1_q)) begin
            forward_a = 2'b10;
        end else if (wb_can_fwd && (wb_q.rd == ex_rs1_q)) begin
            forward_a = 2'b01;
        end
        if (mem_can_fwd && (mem_q.rd == ex_rs2_q)) begin
            forward_b = 2'b10;
        end else if (wb_can_fwd && (wb_q.rd == ex_rs2_q)) begin
            forward_b = 2'b01;
        end
    end

    // Load in EX whose result the ID instruction needs; a frozen pipe never stalls.
    always_comb begin
        stall = ex_is_load & id_valid
              & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2))
              & ~hold;
    end

    // Advance the tracking pipe unless frozen; EX takes a bubble on stall, flush or empty ID.
    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        stall_count_d = stall_count_q;
        ex_bubble     = stall | flush | ~id_valid;
        if (!hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (ex_bubble) begin
                ex_d     = '0;
                ex_rs1_d = 5'd0;
                ex_rs2_d = 5'd0;
            end else begin
                ex_d.valid    = 1'b1;
                ex_d.rd       = id_rd;
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                ex_rs1_d      = id_rs1;
                ex_rs2_d      = id_rs2;
            end
            if (stall && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset wins over hold and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0;
    logic        hold = 1'b0, flush = 1'b0;

    logic [1:0]  fa, fb, fa2, fb2;
    logic        st, st2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    hazard_forward_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .hold(hold), .flush(flush), .forward_a(fa), .forward_b(fb),
        .stall(st), .stall_count(cnt)
    );

    hazard_forward_unit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .hold(hold), .flush(flush), .forward_a(fa2), .forward_b(fb2),
        .stall(st2), .stall_count(cnt2)
    );

    // Reference model: a list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       wr;
        bit       ld;
    } instr_t;

    instr_t pipe [3];
    int     m_cnt16 = 0;
    int     m_cnt2  = 0;

    function automatic bit [1:0] m_fwd(input bit [4:0] rs);
        // Scan producers from youngest (MEM) to oldest (WB).
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].wr && pipe[k].rd != 0 && pipe[k].rd == rs)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        return pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && id_valid && !hold &&
               (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
    endfunction

    always @(posedge clk) begin
        bit s;
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 0};
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (!hold) begin
            s = m_stall();
            if (s) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (s || flush || !id_valid) pipe[0] = '{0, 0, 0, 0, 0, 0};
            else pipe[0] = '{1, id_rd, id_rs1, id_rs2, id_regwrite, id_memread};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("model_fa",   32'(fa),   32'(m_fwd(pipe[0].rs1)));
            check("model_fb",   32'(fb),   32'(m_fwd(pipe[0].rs2)));
            check("model_st",   32'(st),   32'(m_stall()));
            check("model_cnt",  32'(cnt),  32'(m_cnt16));
            check("model_fa2",  32'(fa2),  32'(m_fwd(pipe[0].rs1)));
            check("model_fb2",  32'(fb2),  32'(m_fwd(pipe[0].rs2)));
            check("model_st2",  32'(st2),  32'(m_stall()));
            check("model_cnt2", 32'(cnt2), 32'(m_cnt2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = wr; id_memread = ld;
        #1;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_fa", 32'(fa), 0);
        check("rst_fb", 32'(fb), 0);
        check("rst_st", 32'(st), 0);
        check("rst_cnt", 32'(cnt), 0);
        rst = 1'b0;
        armed = 1'b1;

        // ALU chain, back to back: EX/MEM forward
        set_id(1, 1, 2, 5, 1, 0); tick();
        set_id(1, 5, 6, 8, 1, 0); tick();
        check("chain_fa_mem", 32'(fa), 32'h2);
        check("chain_fb_mem", 32'(fb), 0);
        idle(); tick(); tick(); tick();

        // ALU chain with one independent instruction between: MEM/WB forward
        set_id(1, 1, 2, 5, 1, 0); tick();
        set_id(1, 10, 11, 9, 1, 0); tick();
        set_id(1, 5, 6, 8, 1, 0); tick();
        check("chain_fa_wb", 32'(fa), 32'h1);
        idle(); tick(); tick(); tick();

        // Double producer of x7: youngest wins; rs1=x0 never forwards
        set_id(1, 1, 2, 7, 1, 0); tick();
        set_id(1, 3, 4, 7, 1, 0); tick();
        set_id(1, 0, 7, 9, 1, 0); tick();
        check("dbl_fb", 32'(fb), 32'h2);
        check("dbl_fa_x0", 32'(fa), 0);
        idle(); tick(); tick(); tick();

        // x0 producer and x0 load never forward or stall
        set_id(1, 1, 2, 0, 1, 1); tick();
        set_id(1, 0, 0, 4, 1, 0);
        check("x0_no_stall", 32'(st), 0);
        tick();
        check("x0_fa", 32'(fa), 0);
        idle(); tick(); tick(); tick();

        // Load-use: exactly one stall, then MEM/WB forward
        do_reset();
        set_id(1, 1, 2, 3, 1, 1); tick();
        set_id(1, 3, 6, 4, 1, 0);
        check("lu_stall", 32'(st), 1);
        check("lu_cnt0", 32'(cnt), 0);
        tick();
        check("lu_stall_gone", 32'(st), 0);
        check("lu_cnt1", 32'(cnt), 1);
        check("lu_bubble_fa", 32'(fa), 0);
        tick();
        check("lu_fa_wb", 32'(fa), 32'h1);
        idle(); tick(); tick(); tick();

        // Flush: consumer replaced by a bubble
        set_id(1, 1, 2, 12, 1, 0); tick();
        set_id(1, 12, 12, 13, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("flush_fa", 32'(fa), 0);
        check("flush_fb", 32'(fb), 0);
        tick(); tick(); tick();

        // Hold with flush pending: forwarding state frozen for 3 cycles
        set_id(1, 1, 2, 5, 1, 0); tick();
        set_id(1, 5, 6, 8, 1, 0); tick();
        set_id(1, 9, 9, 10, 1, 0);
        hold = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_fa", 32'(fa), 32'h2);
            check("hold_cnt", 32'(cnt), 1);
        end
        hold = 1'b0;
        flush = 1'b0;
        idle(); tick(); tick(); tick();

        // Hold masks a load-use stall and freezes the counter
        set_id(1, 1, 2, 3, 1, 1); tick();
        set_id(1, 3, 0, 4, 1, 0);
        hold = 1'b1;
        #1;
        check("hold_stall_masked", 32'(st), 0);
        tick(); tick();
        check("hold_cnt_frozen", 32'(cnt), 1);
        hold = 1'b0;
        #1;
        check("unhold_stall", 32'(st), 1);
        tick(); tick();
        idle(); tick(); tick(); tick();

        // Saturation: five load-use stalls
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_id(1, 1, 2, 3, 1, 1); tick();
            set_id(1, 2, 3, 4, 1, 0); tick();
            tick();
            idle(); tick(); tick();
        end
        check("sat_cnt2", 32'(cnt2), 3);
        check("sat_cnt16", 32'(cnt), 5);

        // Reset during a stall clears everything
        set_id(1, 1, 2, 3, 1, 1); tick();
        set_id(1, 3, 3, 4, 1, 0);
        check("pre_rst_stall", 32'(st), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("rst_mid_stall", 32'(st), 0);
        check("rst_mid_fa", 32'(fa), 0);
        check("rst_mid_fb", 32'(fb), 0);
        check("rst_mid_cnt", 32'(cnt), 0);
        check("rst_mid_cnt2", 32'(cnt2), 0);
        tick(); tick();

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of the load-use stall event counter.
REQ-002 Ports: clk  input  1  rising-edge clock, the only clock.
REQ-003 Ports: rst  input  1  reset, synchronous, active-high.
REQ-004 Ports: id_valid  input  1  ID-stage instruction is real (not a bubble).
REQ-005 Ports: id_rs1, id_rs2  input  5 each  ID-stage source register addresses.
REQ-006 Ports: id_rd  input  5  ID-stage destination register address.
REQ-007 Ports: id_regwrite, id_memread  input  1 each  ID-stage writes register file / is a load.
REQ-008 Ports: hold  input  1  pipeline freeze (memory wait); tracking registers keep their values.
REQ-009 Ports: flush  input  1  taken branch; the instruction entering EX is replaced by a bubble.
REQ-010 Ports: forward_a, forward_b  output  2 each  forwarding mux selects for the EX operands: 00 = ID/EX register data, 10 = EX/MEM data, 01 = MEM/WB data; 11 is never driven.
REQ-011 Ports: stall  output  1  load-use hazard; freeze PC and IF/ID, bubble ID/EX.
REQ-012 Ports: stall_count  output  CNT_W  number of load-use stall cycles since reset.

Function
REQ-013 The unit SHALL hold three tracking stages, EX, MEM and WB, each made of valid, rd, regwrite and memread; the EX stage SHALL also hold rs1 and rs2.
REQ-014 On each clk edge with rst=0 and hold=0, the unit SHALL shift WB<=MEM and MEM<=EX.
REQ-015 On the same edge, EX SHALL load the ID inputs, or a bubble (all fields 0) when stall=1, flush=1 or id_valid=0.
REQ-016 With hold=1 and rst=0, all tracking stages and stall_count SHALL keep their values; hold has priority over flush and stall, and flush asserted during hold is ignored.
REQ-017 forward_a SHALL be combinational from the tracking registers:
- 10 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1;
- else 01 if WB.valid & WB.regwrite & WB.rd!=0 & WB.rd==EX.rs1;
- else 00.
REQ-018 forward_b SHALL follow the REQ-017 rule using EX.rs2.
REQ-019 When MEM and WB both match, EX/MEM SHALL win (most recent producer).
REQ-020 Register x0 (rd=0) SHALL never forward and never cause a stall.
REQ-021 stall SHALL be combinational: EX.valid & EX.memread & EX.rd!=0 & id_valid & (EX.rd==id_rs1 | EX.rd==id_rs2) & ~hold.
REQ-022 One load followed by one dependent instruction SHALL produce exactly one stall cycle. After the bubble, the load is in MEM and forwarding selects 01 when the dependent instruction reaches EX, where the load data is in MEM/WB.
REQ-023 If stall and flush coincide, EX SHALL take a bubble (both agree).
REQ-024 stall_count SHALL increment by 1 on each edge where stall=1 and hold=0, saturating at all-ones with no wrap.
REQ-025 Latency: forward_* and stall SHALL reflect the tracking state in the same cycle, with no register on the outputs.

Reset
REQ-026 On a clk edge with rst=1, all tracking-stage fields SHALL become 0 and stall_count SHALL become 0, regardless of hold and flush.
REQ-027 While in reset state: forward_a=00, forward_b=00, stall=0.
REQ-028 Reset asserted mid-stall SHALL clear the hazard, so stall=0 on the next cycle when id_valid=0.

Verification
REQ-029 ALU chain: add x5 in ID, next cycle sub using rs1=x5 -> forward_a=10 in that sub's EX cycle. Repeat with one independent instruction between them -> forward_a=01.
REQ-030 Double hazard: x7 written by both MEM and WB instructions while EX.rs2=x7 -> forward_b=10. x0 producer with rs1=0 -> forward_a=00.
REQ-031 Load-use: lw x3 then add rs1=x3 -> stall=1 for exactly 1 cycle and stall_count 0->1. Next cycle EX is a bubble; add in EX gets forward_a=01.
REQ-032 Flush/hold: flush=1 with valid ID -> EX bubble, no forwarding next cycle. hold=1 for 3 cycles -> forward_*, stall and stall_count unchanged; flush during hold has no effect.
REQ-033 Saturation/reset: with CNT_W=2, force 5 stall cycles -> stall_count=3. Assert rst during a stall -> next cycle all outputs 0.
